// File: rtl/neuromorphic_pkg.sv
// Shared types and helpers for the time-multiplexed spiking layer.
package neuromorphic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FIRE  = 2'd2,
    ST_OUT   = 2'd3
  } layer_state_e;

  // Index width for a table of 'depth' entries, never less than one bit.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Add a sign-extended weight to an unsigned potential, clamped to [0, v_max].
  function automatic logic [31:0] clamp_add(input logic [31:0] v,
                                            input logic [31:0] w_ext,
                                            input logic [31:0] v_max);
    logic signed [33:0] sum;
    sum = $signed({2'b00, v}) + $signed({{2{w_ext[31]}}, w_ext});
    if (sum < 34'sd0) return '0;
    if (sum > $signed({2'b00, v_max})) return v_max;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/layer_weight_bank.sv
// Synaptic weight store: one write port, one registered read port.
module layer_weight_bank #(
  parameter int DEPTH  = 64,
  parameter int W_BITS = 8,
  parameter int A_BITS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [A_BITS-1:0] wr_addr_i,
  input  logic [W_BITS-1:0] wr_data_i,
  input  logic [A_BITS-1:0] rd_addr_i,
  output logic [W_BITS-1:0] rd_data_o
);

  logic [W_BITS-1:0] mem_q [DEPTH];
  logic [W_BITS-1:0] rd_q;

  // Weight storage and read register.
  // NOTE: the array is reset element by element so a cleared layer starts from all-zero weights; this forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en_i && (int'(wr_addr_i) < DEPTH)) mem_q[wr_addr_i] <= wr_data_i;
      if (int'(rd_addr_i) < DEPTH) rd_q <= mem_q[rd_addr_i];
      else                         rd_q <= '0;
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/spiking_layer_tdm.sv
// Time-multiplexed spiking layer: one synapse per cycle, one fire step per event.
module spiking_layer_tdm
  import neuromorphic_pkg::*;
#(
  parameter int N_IN   = 8,
  parameter int N_NEU  = 8,
  parameter int W_BITS = 8,
  parameter int V_BITS = 12,
  parameter int REFRAC = 2,
  localparam int A_BITS = addr_bits(N_NEU * N_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic [N_IN-1:0]   in_spikes_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [N_NEU-1:0]  out_spikes_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  input  logic [V_BITS-1:0] threshold_i,
  input  logic [V_BITS-1:0] leak_i,
  input  logic [N_NEU-1:0]  active_mask_i,
  input  logic              wr_en_i,
  input  logic [A_BITS-1:0] wr_addr_i,
  input  logic [W_BITS-1:0] wr_data_i,
  output logic              busy_o,
  output logic [31:0]       total_spikes_o,
  output logic [31:0]       event_count_o
);

  localparam int N       = N_NEU * N_IN;
  localparam int C_BITS  = addr_bits(N + 1);
  localparam int NI_BITS = addr_bits(N_NEU);
  localparam int II_BITS = addr_bits(N_IN);
  localparam int R_BITS  = addr_bits(REFRAC + 1);
  localparam logic [31:0] V_MAX32 = (32'd1 << V_BITS) - 32'd1;

  layer_state_e state_q, state_d;

  logic [C_BITS-1:0]  cnt_q;
  logic [NI_BITS-1:0] acc_n_q;
  logic [II_BITS-1:0] acc_i_q;
  logic [N_IN-1:0]    spikes_q;
  logic [V_BITS-1:0]  v_q      [N_NEU];
  logic [R_BITS-1:0]  refrac_q [N_NEU];
  logic [N_NEU-1:0]   out_spikes_q;
  logic               out_valid_q;
  logic [31:0]        total_q, events_q;

  logic               accept, accum_last, acc_add;
  logic [W_BITS-1:0]  rd_w;
  logic [31:0]        w_ext, acc_full;
  logic [V_BITS-1:0]  fire_v [N_NEU];
  logic [R_BITS-1:0]  fire_r [N_NEU];
  logic [N_NEU-1:0]   fire_spk;
  logic [31:0]        spike_pop;

  assign accept     = (state_q == ST_IDLE) && enable_i && in_valid_i;
  assign accum_last = (cnt_q == C_BITS'(N));

  // Weights change only between events; reads walk the table during ACCUM.
  layer_weight_bank #(
    .DEPTH (N),
    .W_BITS(W_BITS),
    .A_BITS(A_BITS)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (wr_en_i && (state_q == ST_IDLE)),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .rd_addr_i(cnt_q[A_BITS-1:0]),
    .rd_data_o(rd_w)
  );

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ACCUM;
      ST_ACCUM: if (accum_last) state_d = ST_FIRE;
      ST_FIRE:  state_d = ST_OUT;
      ST_OUT:   if (out_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Read-address counter and the (neuron, input) pair whose weight is arriving.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_n_q  <= '0;
      acc_i_q  <= '0;
      spikes_q <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      acc_n_q  <= '0;
      acc_i_q  <= '0;
      spikes_q <= in_spikes_i;
    end else if (state_q == ST_ACCUM) begin
      if (!accum_last) cnt_q <= cnt_q + 1'b1;
      // Weight data lags the address by one cycle, so the pair index starts stepping at cnt 1.
      if (cnt_q != '0) begin
        if (acc_i_q == II_BITS'(N_IN - 1)) begin
          acc_i_q <= '0;
          acc_n_q <= acc_n_q + 1'b1;
        end else begin
          acc_i_q <= acc_i_q + 1'b1;
        end
      end
    end
  end

  assign w_ext    = {{(32 - W_BITS){rd_w[W_BITS-1]}}, rd_w};
  assign acc_full = clamp_add(32'(v_q[acc_n_q]), w_ext, V_MAX32);
  assign acc_add  = (state_q == ST_ACCUM) && (cnt_q != '0) && spikes_q[acc_i_q]
                 && active_mask_i[acc_n_q] && (refrac_q[acc_n_q] == '0);

  // Fire rules per neuron: mask, then refractory, then threshold, then leak.
  always_comb begin
    fire_spk  = '0;
    spike_pop = '0;
    for (int n = 0; n < N_NEU; n++) begin
      fire_v[n] = v_q[n];
      fire_r[n] = refrac_q[n];
      if (!active_mask_i[n]) begin
        fire_v[n] = '0;
        fire_r[n] = '0;
      end else if (refrac_q[n] != '0) begin
        fire_v[n] = '0;
        fire_r[n] = refrac_q[n] - 1'b1;
      end else if (v_q[n] >= threshold_i) begin
        fire_spk[n] = 1'b1;
        fire_v[n]   = '0;
        fire_r[n]   = R_BITS'(REFRAC);
      end else begin
        fire_v[n] = (v_q[n] > leak_i) ? v_q[n] - leak_i : '0;
      end
      spike_pop = spike_pop + 32'(fire_spk[n]);
    end
  end

  // Membrane and refractory state: accumulate in ACCUM, settle in FIRE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < N_NEU; n++) begin
        v_q[n]      <= '0;
        refrac_q[n] <= '0;
      end
    end else if (state_q == ST_FIRE) begin
      for (int n = 0; n < N_NEU; n++) begin
        v_q[n]      <= fire_v[n];
        refrac_q[n] <= fire_r[n];
      end
    end else if (acc_add) begin
      v_q[acc_n_q] <= acc_full[V_BITS-1:0];
    end
  end

  // Output handshake register and wrapping statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_spikes_q <= '0;
      out_valid_q  <= 1'b0;
      total_q      <= '0;
      events_q     <= '0;
    end else begin
      if (accept) events_q <= events_q + 32'd1;
      if (state_q == ST_FIRE) begin
        out_spikes_q <= fire_spk;
        out_valid_q  <= 1'b1;
        total_q      <= total_q + spike_pop;
      end else if ((state_q == ST_OUT) && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready_o     = (state_q == ST_IDLE) && enable_i;
  assign busy_o         = (state_q != ST_IDLE);
  assign out_spikes_o   = out_spikes_q;
  assign out_valid_o    = out_valid_q;
  assign total_spikes_o = total_q;
  assign event_count_o  = events_q;

endmodule

// File: tb/tb_spiking_layer_tdm.sv
// Directed bench for spiking_layer_tdm at default parameters.
module tb_spiking_layer_tdm;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_i = 1'b1;
  logic [7:0]  in_spikes_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [7:0]  out_spikes_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [11:0] threshold_i = 12'd100;
  logic [11:0] leak_i = '0;
  logic [7:0]  active_mask_i = 8'hFF;
  logic        wr_en_i = 1'b0;
  logic [5:0]  wr_addr_i = '0;
  logic [7:0]  wr_data_i = '0;
  logic        busy_o;
  logic [31:0] total_spikes_o, event_count_o;

  int total = 0;
  int bad   = 0;

  spiking_layer_tdm dut (
    .clk(clk), .rst(rst), .enable_i(enable_i),
    .in_spikes_i(in_spikes_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_spikes_o(out_spikes_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .threshold_i(threshold_i), .leak_i(leak_i), .active_mask_i(active_mask_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .busy_o(busy_o), .total_spikes_o(total_spikes_o), .event_count_o(event_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, landing 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic write_w(input int addr, input logic [7:0] data);
    wr_en_i   = 1'b1;
    wr_addr_i = 6'(addr);
    wr_data_i = data;
    step(1);
    wr_en_i = 1'b0;
  endtask

  // Present one vector, wait (bounded) for out_valid, return spikes and latency.
  task automatic start_and_wait(input logic [7:0] spk, output logic [7:0] got, output int lat);
    in_spikes_i = spk;
    in_valid_i  = 1'b1;
    step(1);
    in_valid_i = 1'b0;
    lat = 0;
    while (!out_valid_o && lat < 200) begin
      step(1);
      lat++;
    end
    if (!out_valid_o) check("out_valid_timeout", 32'(out_valid_o), 32'd1);
    got = out_spikes_o;
  endtask

  // Full event with out_ready held high; checks the output vector.
  task automatic do_event(input string tag, input logic [7:0] spk, input logic [7:0] exp);
    logic [7:0] got;
    int lat;
    start_and_wait(spk, got, lat);
    check(tag, 32'(got), 32'(exp));
    step(1);
  endtask

  initial begin
    logic [7:0] got;
    int lat;

    // Reset state
    do_reset();
    check("rst_out_spikes", 32'(out_spikes_o), 32'd0);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_total", total_spikes_o, 32'd0);
    check("rst_events", event_count_o, 32'd0);

    // enable low blocks acceptance
    enable_i = 1'b0;
    in_valid_i = 1'b1;
    step(3);
    check("en0_in_ready", 32'(in_ready_o), 32'd0);
    check("en0_busy", 32'(busy_o), 32'd0);
    check("en0_events", event_count_o, 32'd0);
    in_valid_i = 1'b0;
    enable_i = 1'b1;

    // Refractory: w[0]=50, thr=100, leak=0; also first-event latency
    threshold_i = 12'd100;
    leak_i = 12'd0;
    write_w(0, 8'd50);
    start_and_wait(8'h01, got, lat);
    check("lat_to_valid", 32'(lat), 32'(N + 2));
    check("refrac_e1", 32'(got), 32'h00);
    step(1);
    check("refrac_back_idle", 32'(busy_o), 32'd0);
    do_event("refrac_e2", 8'h01, 8'h01);
    do_event("refrac_e3", 8'h01, 8'h00);
    do_event("refrac_e4", 8'h01, 8'h00);
    do_event("refrac_e5", 8'h01, 8'h00);
    do_event("refrac_e6", 8'h01, 8'h01);
    check("refrac_total", total_spikes_o, 32'd2);
    check("refrac_events", event_count_o, 32'd6);

    // Leak: w=30, leak=10 -> v 20,40,60,80 then fire on event 5
    do_reset();
    leak_i = 12'd10;
    write_w(0, 8'd30);
    do_event("leak_e1", 8'h01, 8'h00);
    do_event("leak_e2", 8'h01, 8'h00);
    do_event("leak_e3", 8'h01, 8'h00);
    do_event("leak_e4", 8'h01, 8'h00);
    do_event("leak_e5", 8'h01, 8'h01);
    do_event("leak_e6_refrac", 8'h01, 8'h00);
    do_event("leak_e7_refrac", 8'h01, 8'h00);
    // Build v0 to 60, mask it off for one event, then it must restart from 0
    do_event("mask_e8", 8'h01, 8'h00);
    do_event("mask_e9", 8'h01, 8'h00);
    do_event("mask_e10", 8'h01, 8'h00);
    active_mask_i = 8'hFE;
    do_event("mask_off", 8'h01, 8'h00);
    active_mask_i = 8'hFF;
    do_event("mask_r1", 8'h01, 8'h00);
    do_event("mask_r2", 8'h01, 8'h00);
    do_event("mask_r3", 8'h01, 8'h00);
    do_event("mask_r4", 8'h01, 8'h00);
    do_event("mask_r5", 8'h01, 8'h01);

    // Saturation (n2 weights 127) and negative weights (n1 weights -128)
    do_reset();
    threshold_i = 12'd4095;
    leak_i = 12'd0;
    for (int i = 0; i < 8; i++) write_w(16 + i, 8'd127);
    for (int i = 0; i < 8; i++) write_w(8 + i, 8'h80);
    do_event("sat_e1", 8'hFF, 8'h00);
    do_event("sat_e2", 8'hFF, 8'h00);
    do_event("sat_e3", 8'hFF, 8'h00);
    do_event("sat_e4", 8'hFF, 8'h00);
    do_event("sat_e5", 8'hFF, 8'h04);
    check("sat_total", total_spikes_o, 32'd1);
    // threshold 0: all but refractory n2 fire, even on an empty vector
    threshold_i = 12'd0;
    do_event("thr0_fire", 8'h00, 8'hFB);
    check("thr0_total", total_spikes_o, 32'd8);
    check("thr0_events", event_count_o, 32'd6);

    // Backpressure with threshold 0 from reset: every neuron fires
    do_reset();
    out_ready_i = 1'b0;
    in_spikes_i = 8'h00;
    in_valid_i = 1'b1;
    step(1);
    in_valid_i = 1'b0;
    enable_i = 1'b0;  // dropping enable mid-event must not stall it
    check("bp_busy", 32'(busy_o), 32'd1);
    check("bp_in_ready_accum", 32'(in_ready_o), 32'd0);
    lat = 0;
    while (!out_valid_o && lat < 200) begin
      step(1);
      lat++;
    end
    check("bp_valid_seen", 32'(out_valid_o), 32'd1);
    enable_i = 1'b1;
    in_valid_i = 1'b1;
    wr_en_i = 1'b1;
    wr_addr_i = 6'd0;
    wr_data_i = 8'd127;
    for (int c = 0; c < 10; c++) begin
      step(1);
      check("bp_valid_hold", 32'(out_valid_o), 32'd1);
      check("bp_spikes_hold", 32'(out_spikes_o), 32'hFF);
      check("bp_in_ready", 32'(in_ready_o), 32'd0);
    end
    in_valid_i = 1'b0;
    wr_en_i = 1'b0;
    out_ready_i = 1'b1;
    step(1);
    check("bp_release_valid", 32'(out_valid_o), 32'd0);
    check("bp_release_idle", 32'(busy_o), 32'd0);
    check("bp_spikes_after", 32'(out_spikes_o), 32'hFF);
    check("bp_events", event_count_o, 32'd1);
    check("bp_total", total_spikes_o, 32'd8);
    // Drain refractory, then a write during backpressure must not have landed
    do_event("bp_drain1", 8'h00, 8'h00);
    do_event("bp_drain2", 8'h00, 8'h00);
    threshold_i = 12'd100;
    do_event("bp_wr_ignored", 8'h01, 8'h00);

    // Mid-event reset at ACCUM cycle 20
    in_spikes_i = 8'hFF;
    in_valid_i = 1'b1;
    step(1);
    in_valid_i = 1'b0;
    step(19);
    check("mid_busy_before", 32'(busy_o), 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_busy", 32'(busy_o), 32'd0);
    check("mid_events", event_count_o, 32'd0);
    check("mid_total", total_spikes_o, 32'd0);
    check("mid_in_ready", 32'(in_ready_o), 32'd1);
    step(80);
    check("mid_no_valid", 32'(out_valid_o), 32'd0);
    check("mid_out_spikes", 32'(out_spikes_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
